// File: rtl/activation_issuer.sv
// Streams filter words, then image pixels in raster order, from two synchronous-read buffers
// to the allocator array, honouring the OR-ed stall inputs on each issue port.
module activation_issuer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 18,
  parameter int FLEN_W = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        img_width,
  input  logic [7:0]        img_height,
  input  logic [FLEN_W-1:0] filter_length,
  output logic [ADDR_W-1:0] img_mem_addr,
  input  logic [DATA_W-1:0] img_mem_data,
  output logic [FLEN_W-1:0] flt_mem_addr,
  input  logic [DATA_W-1:0] flt_mem_data,
  output logic [7:0]        issue_a_x,
  output logic [7:0]        issue_a_y,
  output logic [DATA_W-1:0] issue_a_data,
  output logic              issue_a_blocked,
  input  logic              issue_a_block,
  output logic [FLEN_W-1:0] filter_issue_counter,
  output logic [DATA_W-1:0] filter_data,
  output logic              filter_blocked,
  input  logic              filter_block,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FLT_FETCH = 3'd1,
    FLT_ISSUE = 3'd2,
    PIX_FETCH = 3'd3,
    PIX_ISSUE = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t            state_r, state_nxt_s;
  logic [FLEN_W-1:0] flt_cnt_r, flt_cnt_nxt_s;
  logic [7:0]        x_r, x_nxt_s, y_r, y_nxt_s;
  logic [ADDR_W-1:0] pix_idx_r, pix_idx_nxt_s;
  logic              filter_blocked_r, issue_a_blocked_r, busy_r, done_r;

  logic flt_empty_s, pix_empty_s;
  logic flt_xfer_s, flt_last_s, pix_xfer_s, row_end_s, pix_last_s;

  assign flt_empty_s = (filter_length == {FLEN_W{1'b0}});
  assign pix_empty_s = (img_width == 8'd0) || (img_height == 8'd0);
  assign flt_xfer_s  = (state_r == FLT_ISSUE) && !filter_block && !rst;
  assign pix_xfer_s  = (state_r == PIX_ISSUE) && !issue_a_block && !rst;
  assign flt_last_s  = (flt_cnt_r == filter_length - {{(FLEN_W-1){1'b0}}, 1'b1});
  assign row_end_s   = (x_r == img_width - 8'd1);
  assign pix_last_s  = row_end_s && (y_r == img_height - 8'd1);

  // Filter word index: advances on transfer, wraps to 0 after the last word.
  always_comb begin
    flt_cnt_nxt_s = flt_cnt_r;
    if (flt_xfer_s) begin
      if (flt_last_s) begin
        flt_cnt_nxt_s = {FLEN_W{1'b0}};
      end else begin
        flt_cnt_nxt_s = flt_cnt_r + {{(FLEN_W-1){1'b0}}, 1'b1};
      end
    end else begin
      flt_cnt_nxt_s = flt_cnt_r;
    end
  end

  // Raster position and linear address: x inner, y outer, all back to 0 after the last pixel.
  always_comb begin
    x_nxt_s       = x_r;
    y_nxt_s       = y_r;
    pix_idx_nxt_s = pix_idx_r;
    if (pix_xfer_s) begin
      if (pix_last_s) begin
        x_nxt_s       = 8'd0;
        y_nxt_s       = 8'd0;
        pix_idx_nxt_s = {ADDR_W{1'b0}};
      end else if (row_end_s) begin
        x_nxt_s       = 8'd0;
        y_nxt_s       = y_r + 8'd1;
        pix_idx_nxt_s = pix_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        x_nxt_s       = x_r + 8'd1;
        pix_idx_nxt_s = pix_idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end else begin
      x_nxt_s       = x_r;
      y_nxt_s       = y_r;
      pix_idx_nxt_s = pix_idx_r;
    end
  end

  // Phase sequencing; empty filter or empty image phases are skipped.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (!flt_empty_s)      state_nxt_s = FLT_FETCH;
          else if (!pix_empty_s) state_nxt_s = PIX_FETCH;
          else                   state_nxt_s = DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      FLT_FETCH: state_nxt_s = FLT_ISSUE;
      FLT_ISSUE: begin
        if (flt_xfer_s && flt_last_s) begin
          state_nxt_s = pix_empty_s ? DONE : PIX_FETCH;
        end else begin
          state_nxt_s = FLT_ISSUE;
        end
      end
      PIX_FETCH: state_nxt_s = PIX_ISSUE;
      PIX_ISSUE: begin
        if (pix_xfer_s && pix_last_s) state_nxt_s = DONE;
        else                          state_nxt_s = PIX_ISSUE;
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, counters and registered status flags; reset aborts any layer in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      flt_cnt_r         <= {FLEN_W{1'b0}};
      x_r               <= 8'd0;
      y_r               <= 8'd0;
      pix_idx_r         <= {ADDR_W{1'b0}};
      filter_blocked_r  <= 1'b1;
      issue_a_blocked_r <= 1'b1;
      busy_r            <= 1'b0;
      done_r            <= 1'b0;
    end else begin
      state_r           <= state_nxt_s;
      flt_cnt_r         <= flt_cnt_nxt_s;
      x_r               <= x_nxt_s;
      y_r               <= y_nxt_s;
      pix_idx_r         <= pix_idx_nxt_s;
      filter_blocked_r  <= (state_nxt_s != FLT_ISSUE);
      issue_a_blocked_r <= (state_nxt_s != PIX_ISSUE);
      busy_r            <= (state_nxt_s != IDLE) && (state_nxt_s != DONE);
      done_r            <= (state_nxt_s == DONE);
    end
  end

  // Read addresses run on the next index so the buffer's read register presents the word
  // the cycle after a transfer; during a stall they hold, so the read data stays bit-stable.
  assign flt_mem_addr         = flt_cnt_nxt_s;
  assign img_mem_addr         = pix_idx_nxt_s;
  assign filter_issue_counter = flt_cnt_r;
  assign filter_data          = filter_blocked_r ? {DATA_W{1'b0}} : flt_mem_data;
  assign filter_blocked       = filter_blocked_r;
  assign issue_a_x            = x_r;
  assign issue_a_y            = y_r;
  assign issue_a_data         = issue_a_blocked_r ? {DATA_W{1'b0}} : img_mem_data;
  assign issue_a_blocked      = issue_a_blocked_r;
  assign busy                 = busy_r;
  assign done                 = done_r;

endmodule
